// File: rtl/alu_issue.sv
// ID/EX issue slot: decodes a MIPS instruction into ALU operands and holds
// it in a single output register behind a valid/ready handshake.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// Upstream side: accept = in_valid && in_ready && !flush.
// Downstream side: consume = out_valid && out_ready.
// in_ready is combinational (!out_valid || out_ready), so a consume and an
// accept can share one edge, giving one instruction per cycle.
// While out_valid && !out_ready, every output stays stable.
module alu_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    output logic [4:0]  dest,
    output logic        reg_write,
    output logic        illegal,
    output logic [7:0]  illegal_cnt
);

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b0111;
    localparam logic [3:0] OP_LUI  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b1001;
    localparam logic [3:0] OP_SRL  = 4'b1010;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;

    logic [31:0] d_a;
    logic [31:0] d_b;
    logic [3:0]  d_op;
    logic [4:0]  d_dest;
    logic        d_legal;
    logic        accept;
    logic        consume;

    assign opcode   = instr[31:26];
    assign funct    = instr[5:0];
    assign imm      = instr[15:0];
    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_zext = {16'b0, imm};

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign consume  = out_valid && out_ready;

    // Decode the offered instruction into operands, opcode and destination.
    always_comb begin
        d_a     = 32'b0;
        d_b     = 32'b0;
        d_op    = OP_NOP;
        d_dest  = 5'b0;
        d_legal = 1'b1;
        if (opcode == 6'b000000) begin
            d_a    = rs_data;
            d_b    = rt_data;
            d_dest = instr[15:11];
            case (funct)
                6'b100000, 6'b100001: d_op = OP_ADD;
                6'b100010, 6'b100011: d_op = OP_SUB;
                6'b100100:            d_op = OP_AND;
                6'b100101:            d_op = OP_OR;
                6'b100111:            d_op = OP_NOR;
                6'b101010:            d_op = OP_SLT;
                6'b101011:            d_op = OP_SLTU;
                6'b000000: begin
                    d_op = OP_SLL;
                    d_a  = {27'b0, instr[10:6]};
                end
                6'b000010: begin
                    d_op = OP_SRL;
                    d_a  = {27'b0, instr[10:6]};
                end
                6'b000100:            d_op = OP_SLL;
                6'b000110:            d_op = OP_SRL;
                default:              d_legal = 1'b0;
            endcase
        end else begin
            d_a    = rs_data;
            d_dest = instr[20:16];
            case (opcode)
                6'b001000, 6'b001001: begin d_op = OP_ADD;  d_b = imm_sext; end
                6'b001010:            begin d_op = OP_SLT;  d_b = imm_sext; end
                6'b001011:            begin d_op = OP_SLTU; d_b = imm_sext; end
                6'b001100:            begin d_op = OP_AND;  d_b = imm_zext; end
                6'b001101:            begin d_op = OP_OR;   d_b = imm_zext; end
                6'b001111: begin
                    d_op = OP_LUI;
                    d_a  = 32'b0;
                    d_b  = imm_zext;
                end
                default:              d_legal = 1'b0;
            endcase
        end
        // Undecodable entries travel through as a harmless NOP.
        if (!d_legal) begin
            d_a    = 32'b0;
            d_b    = 32'b0;
            d_op   = OP_NOP;
            d_dest = 5'b0;
        end
    end

    // Output slot: flush wins, then load on accept, else empty on consume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            alu_a     <= 32'b0;
            alu_b     <= 32'b0;
            alu_op    <= OP_NOP;
            dest      <= 5'b0;
            reg_write <= 1'b0;
            illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            alu_a     <= d_a;
            alu_b     <= d_b;
            alu_op    <= d_op;
            dest      <= d_dest;
            reg_write <= d_legal && (d_dest != 5'b0);
            illegal   <= !d_legal;
        end else if (consume) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating tally of accepted illegal instructions; flush leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_cnt <= 8'd0;
        end else if (accept && !d_legal && (illegal_cnt != 8'hFF)) begin
            illegal_cnt <= illegal_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed scenarios plus randomized traffic against a
// queue-based reference of the issue slot.
module tb_alu_issue;

    localparam int W = 75;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [4:0]  dest;
    logic        reg_write;
    logic        illegal;
    logic [7:0]  illegal_cnt;

    int          n_checks;
    int          n_fail;
    logic [W-1:0] exp_q[$];
    int          exp_cnt;

    alu_issue dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a),
        .alu_b(alu_b), .alu_op(alu_op), .dest(dest), .reg_write(reg_write),
        .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected slot contents {illegal, reg_write, dest, op, b, a} from the ISA table.
    function automatic logic [W-1:0] ref_decode(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  o;
        logic [4:0]  d;
        logic        ok;
        logic [31:0] se;
        logic [31:0] ze;
        op = ins[31:26];
        fn = ins[5:0];
        se = {{16{ins[15]}}, ins[15:0]};
        ze = {16'h0, ins[15:0]};
        ok = 1'b1;
        a  = rs;
        b  = rt;
        o  = 4'd0;
        d  = (op == 6'd0) ? ins[15:11] : ins[20:16];
        if (op == 6'd0) begin
            if (fn == 6'h20 || fn == 6'h21) o = 4'd1;
            else if (fn == 6'h22 || fn == 6'h23) o = 4'd2;
            else if (fn == 6'h24) o = 4'd3;
            else if (fn == 6'h25) o = 4'd4;
            else if (fn == 6'h27) o = 4'd7;
            else if (fn == 6'h2A) o = 4'd5;
            else if (fn == 6'h2B) o = 4'd6;
            else if (fn == 6'h00) begin o = 4'd9;  a = 32'(ins[10:6]); end
            else if (fn == 6'h02) begin o = 4'd10; a = 32'(ins[10:6]); end
            else if (fn == 6'h04) o = 4'd9;
            else if (fn == 6'h06) o = 4'd10;
            else ok = 1'b0;
        end else if (op == 6'h08 || op == 6'h09) begin o = 4'd1; b = se; end
        else if (op == 6'h0A) begin o = 4'd5; b = se; end
        else if (op == 6'h0B) begin o = 4'd6; b = se; end
        else if (op == 6'h0C) begin o = 4'd3; b = ze; end
        else if (op == 6'h0D) begin o = 4'd4; b = ze; end
        else if (op == 6'h0F) begin o = 4'd8; a = 32'd0; b = ze; end
        else ok = 1'b0;
        if (!ok) return {1'b1, 1'b0, 5'd0, 4'd0, 32'd0, 32'd0};
        return {1'b0, (d != 5'd0), d, o, b, a};
    endfunction

    function automatic logic [W-1:0] dut_entry();
        return {illegal, reg_write, dest, alu_op, alu_b, alu_a};
    endfunction

    // Random instruction biased towards legal encodings.
    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        int          k;
        r = $urandom;
        k = $urandom_range(0, 22);
        case (k)
            0:  return {6'h00, r[25:6], 6'h20};
            1:  return {6'h00, r[25:6], 6'h23};
            2:  return {6'h00, r[25:6], 6'h24};
            3:  return {6'h00, r[25:6], 6'h25};
            4:  return {6'h00, r[25:6], 6'h27};
            5:  return {6'h00, r[25:6], 6'h2A};
            6:  return {6'h00, r[25:6], 6'h2B};
            7:  return {6'h00, r[25:6], 6'h00};
            8:  return {6'h00, r[25:6], 6'h02};
            9:  return {6'h00, r[25:6], 6'h04};
            10: return {6'h00, r[25:6], 6'h06};
            11: return {6'h08, r[25:0]};
            12: return {6'h09, r[25:0]};
            13: return {6'h0A, r[25:0]};
            14: return {6'h0B, r[25:0]};
            15: return {6'h0C, r[25:0]};
            16: return {6'h0D, r[25:0]};
            17: return {6'h0F, r[25:0]};
            18: return 32'd0;
            19: return {6'h00, r[25:6], 6'h01};
            default: return r;
        endcase
    endfunction

    // Driver + reference: drive one cycle of inputs, predict the edge, then check.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] rs,
                        input logic [31:0] rt, input logic fl, input logic ordy);
        logic         exp_rdy;
        logic         acc;
        logic [W-1:0] e;
        in_valid  = v;
        instr     = ins;
        rs_data   = rs;
        rt_data   = rt;
        flush     = fl;
        out_ready = ordy;
        #1;
        exp_rdy = (exp_q.size() == 0) || ordy;
        chk("in_ready", W'(in_ready), W'(exp_rdy));
        acc = v && exp_rdy && !fl;
        e   = ref_decode(ins, rs, rt);
        if (fl) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(e);
        end
        if (acc && e[W-1] && exp_cnt < 255) exp_cnt++;
        @(posedge clk);
        #1;
        chk("out_valid", W'(out_valid), W'(exp_q.size() != 0));
        if (exp_q.size() != 0) chk("entry", dut_entry(), exp_q[0]);
        chk("illegal_cnt", W'(illegal_cnt), W'(exp_cnt));
    endtask

    task automatic idle_step(input logic ordy);
        step(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, ordy);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        exp_cnt   = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        instr     = 32'd0;
        rs_data   = 32'd0;
        rt_data   = 32'd0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_entry", dut_entry(), W'(0));
        chk("rst_cnt", W'(illegal_cnt), W'(0));
        chk("rst_in_ready", W'(in_ready), W'(1));
        rst = 1'b0;

        // addi $5,$3,-4
        step(1'b1, 32'h2065FFFC, 32'd10, 32'd0, 1'b0, 1'b1);
        chk("addi_op", W'(alu_op), W'(4'b0001));
        chk("addi_a", W'(alu_a), W'(32'd10));
        chk("addi_b", W'(alu_b), W'(32'hFFFFFFFC));
        chk("addi_dest", W'(dest), W'(5));
        chk("addi_rw", W'(reg_write), W'(1));
        // sll $2,$4,3
        step(1'b1, 32'h000410C0, 32'd99, 32'd7, 1'b0, 1'b1);
        chk("sll_op", W'(alu_op), W'(4'b1001));
        chk("sll_a", W'(alu_a), W'(32'd3));
        chk("sll_b", W'(alu_b), W'(32'd7));
        chk("sll_dest", W'(dest), W'(2));
        // lui $1,0x1234
        step(1'b1, 32'h3C011234, 32'd55, 32'd66, 1'b0, 1'b1);
        chk("lui_op", W'(alu_op), W'(4'b1000));
        chk("lui_b", W'(alu_b), W'(32'h00001234));
        chk("lui_a", W'(alu_a), W'(0));
        // nop (instr=0) is SLL without write-back
        step(1'b1, 32'd0, 32'd1, 32'd2, 1'b0, 1'b1);
        chk("nop_rw", W'(reg_write), W'(0));
        chk("nop_op", W'(alu_op), W'(4'b1001));

        // flush with a held entry and a new offer
        step(1'b1, 32'h2065FFFC, 32'd1, 32'd0, 1'b1, 1'b0);
        chk("flush_valid", W'(out_valid), W'(0));

        // stall for 3 cycles, then drain one per cycle
        step(1'b1, 32'h20A10001, 32'd100, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, gen_instr(), $urandom, $urandom, 1'b0, 1'b0);
            chk("stall_in_ready", W'(in_ready), W'(0));
        end
        for (int i = 0; i < 4; i++) step(1'b1, gen_instr(), $urandom, $urandom, 1'b0, 1'b1);
        idle_step(1'b1);
        chk("drain_empty", W'(out_valid), W'(0));

        // illegal opcode flood saturates the counter
        for (int i = 0; i < 300; i++) step(1'b1, {6'h3F, 26'($urandom)}, $urandom, $urandom, 1'b0, 1'b1);
        chk("sat_cnt", W'(illegal_cnt), W'(255));
        chk("sat_illegal", W'(illegal), W'(1));
        chk("sat_op", W'(alu_op), W'(0));
        // flush must not disturb the count
        step(1'b1, 32'h2065FFFC, 32'd1, 32'd0, 1'b1, 1'b1);
        chk("flush_cnt", W'(illegal_cnt), W'(255));

        // asynchronous reset while an entry is stalled
        step(1'b1, 32'h2065FFFC, 32'd10, 32'd0, 1'b0, 1'b0);
        idle_step(1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", W'(out_valid), W'(0));
        chk("arst_entry", dut_entry(), W'(0));
        chk("arst_cnt", W'(illegal_cnt), W'(0));
        chk("arst_in_ready", W'(in_ready), W'(1));
        #1 rst = 1'b0;
        exp_q.delete();
        exp_cnt = 0;
        step(1'b1, 32'h2065FFFC, 32'd10, 32'd0, 1'b0, 1'b0);
        chk("arst_addi_valid", W'(out_valid), W'(1));
        chk("arst_addi_b", W'(alu_b), W'(32'hFFFFFFFC));

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 3) != 0, gen_instr(), $urandom, $urandom,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-002 Port rst, input, 1: reset, asynchronous, active-high.
REQ-003 Port in_valid, input, 1: upstream offers instr/rs_data/rt_data this cycle.
REQ-004 Port in_ready, output, 1: stage accepts the offer this cycle.
REQ-005 Port instr, input, 32: MIPS instruction word.
REQ-006 Port rs_data, input, 32: register-file value of instr[25:21].
REQ-007 Port rt_data, input, 32: register-file value of instr[20:16].
REQ-008 Port flush, input, 1: kill the held and incoming entries.
REQ-009 Port out_valid, output, 1: ALU operands are valid.
REQ-010 Port out_ready, input, 1: EX stage consumes the entry this cycle.
REQ-011 Port alu_a, output, 32: ALU A operand.
REQ-012 Port alu_b, output, 32: ALU B operand.
REQ-013 Port alu_op, output, 4: ALU opcode: NOP 0000, ADD 0001, SUB 0010, AND 0011, OR 0100, SLT 0101, SLTU 0110, NOR 0111, LUI 1000, SLL 1001, SRL 1010.
REQ-014 Port dest, output, 5: destination register number.
REQ-015 Port reg_write, output, 1: the result is to be written back.
REQ-016 Port illegal, output, 1: the held entry is an undecodable instruction.
REQ-017 Port illegal_cnt, output, 8: saturating count of accepted illegal instructions.

Function
REQ-018 Stage SHALL be one output register (ID/EX slot); in_ready = !out_valid || out_ready, combinational.
REQ-019 Accept = in_valid && in_ready && !flush; on accept, decoded fields SHALL load at the next edge with out_valid=1 (latency 1 cycle).
REQ-020 Consume = out_valid && out_ready; consume without accept SHALL clear out_valid; consume with accept SHALL reload (full throughput, 1 instr/cycle).
REQ-021 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-022 flush=1 SHALL clear out_valid at the next edge and block acceptance in that cycle, regardless of in_valid/out_ready.
REQ-023 R-type (op=000000) decode by funct: 100000/100001 ADD; 100010/100011 SUB; 100100 AND; 100101 OR; 100111 NOR; 101010 SLT; 101011 SLTU; A=rs_data, B=rt_data, dest=instr[15:11].
REQ-024 funct 000000 SLL and 000010 SRL: A={27'b0,instr[10:6]}, B=rt_data; funct 000100 SLLV and 000110 SRLV: A=rs_data, B=rt_data; dest=instr[15:11].
REQ-025 I-type: 001000/001001 ADD, 001010 SLT, 001011 SLTU, with B = sign-extended imm; 001100 AND, 001101 OR, with B = zero-extended imm; A=rs_data, dest=instr[20:16].
REQ-026 LUI (001111): alu_op=LUI, A=0, B={16'b0,instr[15:0]}, dest=instr[20:16].
REQ-027 reg_write=1 for every legal decode with dest!=0, otherwise 0; instr=0 decodes as SLL with reg_write=0.
REQ-028 Any other op/funct: alu_op=NOP, A=B=0, dest=0, reg_write=0, illegal=1; the entry still traverses the handshake.
REQ-029 illegal_cnt SHALL increment by 1 on each accepted illegal instruction, saturate at 255, and be unaffected by flush.

Reset
REQ-030 rst=1 SHALL immediately force out_valid=0, alu_a=alu_b=0, alu_op=0000, dest=0, reg_write=0, illegal=0, illegal_cnt=0; in_ready=1 while rst is held and after release.
REQ-031 Reset mid-handshake SHALL discard the held entry; the first accept after release behaves per REQ-019.

Verification
REQ-032 addi $5,$3,-4 (0x2065FFFC), rs_data=10, out_ready=1 -> next cycle: out_valid=1, alu_op=0001, A=10, B=0xFFFFFFFC, dest=5, reg_write=1.
REQ-033 sll $2,$4,3 (0x000410C0), rt_data=7 -> alu_op=1001, A=3, B=7, dest=2; lui $1,0x1234 -> alu_op=1000, B=0x00001234.
REQ-034 Back-to-back accepts with out_ready held 0 for 3 cycles -> in_ready=0 and outputs stable for those 3 cycles, then one consume per cycle with no entry lost or duplicated.
REQ-035 flush asserted with out_valid=1 and in_valid=1 -> next cycle out_valid=0; the incoming instruction is not accepted.
REQ-036 300 accepted instructions with op=111111 -> alu_op=0000, illegal=1 on each entry, illegal_cnt saturates at 255.
REQ-037 rst pulsed between clock edges while an entry is stalled -> outputs reach their reset values without waiting for a clock edge; a new addi is accepted on the first edge after release.
